// File: rtl/n2_lsu_q.sv
// n2_lsu_q: in-order load/store queue between issue and the data-memory port.
// Entries are issued in order, complete in order, and misaligned accesses
// are retired as exceptions without touching the bus.
module n2_lsu_q #(
  parameter int DEPTH  = 8,
  parameter int UID_W  = 8,
  parameter int REG_W  = 5,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_v_i,
  output logic                     enq_rdy_o,
  input  logic                     enq_we_i,
  input  logic [1:0]               enq_size_i,
  input  logic                     enq_signed_i,
  input  logic [31:0]              enq_addr_i,
  input  logic [31:0]              enq_wdata_i,
  input  logic [REG_W-1:0]         enq_rd_i,
  input  logic [UID_W-1:0]         enq_uid_i,
  input  logic                     flush_i,
  output logic                     data_req_o,
  input  logic                     data_gnt_i,
  output logic                     data_we_o,
  output logic [31:0]              data_addr_o,
  output logic [31:0]              data_wdata_o,
  output logic [3:0]               data_wstrb_o,
  input  logic                     data_ready_i,
  input  logic [31:0]              data_rdata_i,
  output logic                     wb_v_o,
  output logic                     wb_we_o,
  output logic [REG_W-1:0]         wb_rd_o,
  output logic [31:0]              wb_data_o,
  output logic [UID_W-1:0]         wb_uid_o,
  output logic                     exc_v_o,
  output logic [UID_W-1:0]         exc_uid_o,
  output logic [31:0]              exc_addr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic             we;
    logic [1:0]       size;
    logic             sgn;
    logic             mis;
    logic [3:0]       wstrb;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [REG_W-1:0] rd;
    logic [UID_W-1:0] uid;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        inc;
  logic [PW-1:0] wr_ptr, iss_ptr, cmp_ptr, iss_nxt;
  logic [AW-1:0] wr_idx, iss_idx, cmp_idx;
  logic          full, queued, enq_acc, bypass, head_v;
  logic          head_we, head_mis;
  logic [31:0]   head_addr, head_wdata;
  logic [3:0]    head_wstrb;
  logic [UID_W-1:0] head_uid;
  logic          grant, exc, resp;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic [31:0]   ld_data;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign iss_idx = iss_ptr[AW-1:0];
  assign cmp_idx = cmp_ptr[AW-1:0];

  assign count_o   = wr_ptr - cmp_ptr;
  assign full      = (count_o == PW'(DEPTH));
  assign enq_rdy_o = ~full;
  assign enq_acc   = enq_v_i & ~full & ~flush_i;
  assign queued    = (iss_ptr != wr_ptr);

  // Build the incoming entry: alignment check, strobes and lane-replicated data
  always_comb begin
    inc       = '0;
    inc.we    = enq_we_i;
    inc.size  = enq_size_i;
    inc.sgn   = enq_signed_i;
    inc.addr  = enq_addr_i;
    inc.rd    = enq_rd_i;
    inc.uid   = enq_uid_i;
    case (enq_size_i)
      2'd2: begin
        inc.mis   = 1'b0;
        inc.wstrb = 4'b0001 << enq_addr_i[1:0];
        inc.wdata = {4{enq_wdata_i[7:0]}};
      end
      2'd1: begin
        inc.mis   = enq_addr_i[0];
        inc.wstrb = 4'b0011 << enq_addr_i[1:0];
        inc.wdata = {2{enq_wdata_i[15:0]}};
      end
      default: begin
        inc.mis   = |enq_addr_i[1:0];
        inc.wstrb = 4'b1111;
        inc.wdata = enq_wdata_i;
      end
    endcase
  end

  // An empty issue window lets an aligned incoming entry go straight to the bus
  assign bypass = (BYPASS != 0) & ~queued & enq_acc & ~inc.mis;
  assign head_v = queued | bypass;

  assign head_we    = queued ? mem[iss_idx].we    : inc.we;
  assign head_mis   = queued ? mem[iss_idx].mis   : inc.mis;
  assign head_addr  = queued ? mem[iss_idx].addr  : inc.addr;
  assign head_wdata = queued ? mem[iss_idx].wdata : inc.wdata;
  assign head_wstrb = queued ? mem[iss_idx].wstrb : inc.wstrb;
  assign head_uid   = queued ? mem[iss_idx].uid   : inc.uid;

  assign data_req_o   = head_v & ~head_mis & ~flush_i & ~reset;
  assign data_we_o    = head_we;
  assign data_addr_o  = head_addr;
  assign data_wdata_o = head_wdata;
  assign data_wstrb_o = head_we ? head_wstrb : 4'b0000;
  assign grant        = data_req_o & data_gnt_i;

  // A misaligned head retires only once every older request has completed
  assign exc        = queued & head_mis & (iss_ptr == cmp_ptr) & ~flush_i & ~reset;
  assign exc_v_o    = exc;
  assign exc_uid_o  = head_uid;
  assign exc_addr_o = head_addr;

  assign resp     = data_ready_i & (iss_ptr != cmp_ptr) & ~reset;
  assign wb_v_o   = resp;
  assign wb_we_o  = resp & ~mem[cmp_idx].we;
  assign wb_rd_o  = mem[cmp_idx].rd;
  assign wb_uid_o = mem[cmp_idx].uid;

  // Select the addressed lane of the response and extend it to 32 bits
  always_comb begin
    lane8   = '0;
    lane16  = '0;
    ld_data = '0;
    case (mem[cmp_idx].addr[1:0])
      2'd0:    lane8 = data_rdata_i[7:0];
      2'd1:    lane8 = data_rdata_i[15:8];
      2'd2:    lane8 = data_rdata_i[23:16];
      default: lane8 = data_rdata_i[31:24];
    endcase
    lane16 = mem[cmp_idx].addr[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (mem[cmp_idx].size)
      2'd2:    ld_data = {{24{mem[cmp_idx].sgn & lane8[7]}}, lane8};
      2'd1:    ld_data = {{16{mem[cmp_idx].sgn & lane16[15]}}, lane16};
      default: ld_data = data_rdata_i;
    endcase
    wb_data_o = mem[cmp_idx].we ? '0 : ld_data;
  end

  assign iss_nxt = iss_ptr + PW'(grant | exc);

  // Pointer state; a flush rewinds the write pointer onto the issue pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      iss_ptr <= '0;
      cmp_ptr <= '0;
    end else begin
      if (flush_i)
        wr_ptr <= iss_nxt;
      else if (enq_acc)
        wr_ptr <= wr_ptr + PW'(1);
      iss_ptr <= iss_nxt;
      cmp_ptr <= cmp_ptr + PW'(resp | exc);
    end
  end

  // Entry storage; written on every accepted enqueue, bypassed or not
  always_ff @(posedge clk) begin
    if (enq_acc)
      mem[wr_idx] <= inc;
  end

endmodule
